// File: rtl/clk_gate_ctrl.sv
// Clock-gate hysteresis and sequencing controller for the core and soc_ifc ICGs.
// Runs on the free-running clock. Gates only after a qualified idle run.
// Releases on any wake event. Keeps a saturating count of gated cycles.
module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int MIN_RUN     = 4,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_cptra_rst_b,
  input  logic             i_clk_gate_en,
  input  logic             i_cpu_halt_status,
  input  logic             i_psel,
  input  logic [63:0]      i_generic_input_wires,
  input  logic             i_cptra_error_fatal,
  input  logic             i_cptra_in_debug_scan_mode,
  input  logic             i_rdc_clk_dis,
  input  logic             i_gated_cnt_clr,
  output logic             o_disable_clk,
  output logic             o_disable_soc_ifc_clk,
  output logic             o_cg_active,
  output logic             o_wake_pulse,
  output logic [CNT_W-1:0] o_gated_cycle_cnt
);

  localparam int HW = (MIN_RUN > 0) ? $clog2(MIN_RUN + 1) : 1;
  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [HW-1:0] HOLDOFF_LOAD = HW'(MIN_RUN);
  localparam logic [IW-1:0] IDLE_LOAD    = IW'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IDLE_WAIT = 2'd1,
    GATED     = 2'd2,
    WAKE      = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [HW-1:0]    r_holdoff_cnt;
  logic [HW-1:0]    w_holdoff_next;
  logic [IW-1:0]    r_idle_cnt;
  logic [IW-1:0]    w_idle_next;
  logic [63:0]      r_wires_f;
  logic             r_cg_active;
  logic             r_wake_pulse;
  logic [CNT_W-1:0] r_gated_cnt;

  logic w_wire_chg;
  logic w_force_on;
  logic w_wake;
  logic w_idle;
  logic w_gated;

  assign w_wire_chg = |(i_generic_input_wires ^ r_wires_f);
  assign w_force_on = i_cptra_error_fatal | i_cptra_in_debug_scan_mode;
  assign w_wake     = !i_clk_gate_en | !i_cpu_halt_status | w_wire_chg | w_force_on;
  assign w_idle     = !w_wake;
  assign w_gated    = (r_state == GATED);

  // State, counters and registered status flags
  always_ff @(posedge i_clk or negedge i_cptra_rst_b) begin
    if (!i_cptra_rst_b) begin
      r_state       <= RUN;
      r_holdoff_cnt <= HOLDOFF_LOAD;
      r_idle_cnt    <= '0;
      r_wires_f     <= '0;
      r_cg_active   <= 1'b0;
      r_wake_pulse  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_holdoff_cnt <= w_holdoff_next;
      r_idle_cnt    <= w_idle_next;
      r_wires_f     <= i_generic_input_wires;
      r_cg_active   <= (w_state_next == GATED);
      r_wake_pulse  <= (w_state_next == WAKE);
    end
  end

  // Next-state logic: holdoff after wake, then a continuous idle run before gating
  always_comb begin
    w_state_next   = r_state;
    w_holdoff_next = r_holdoff_cnt;
    w_idle_next    = r_idle_cnt;
    case (r_state)
      RUN: begin
        if (r_holdoff_cnt != '0) begin
          w_holdoff_next = r_holdoff_cnt - 1'b1;
        end
        if (w_idle && (r_holdoff_cnt == '0)) begin
          w_state_next = IDLE_WAIT;
          w_idle_next  = IDLE_LOAD;
        end
      end
      IDLE_WAIT: begin
        // A wake always wins, even on the cycle the idle count expires
        if (w_wake) begin
          w_state_next   = RUN;
          w_holdoff_next = HOLDOFF_LOAD;
        end else if (r_idle_cnt == '0) begin
          w_state_next = GATED;
        end else begin
          w_idle_next = r_idle_cnt - 1'b1;
        end
      end
      GATED: begin
        if (w_wake) begin
          w_state_next = WAKE;
        end
      end
      WAKE: begin
        w_state_next   = RUN;
        w_holdoff_next = HOLDOFF_LOAD;
      end
      default: begin
        w_state_next   = RUN;
        w_holdoff_next = HOLDOFF_LOAD;
      end
    endcase
  end

  // Gated-cycle telemetry counter: clear wins, otherwise saturating increment
  always_ff @(posedge i_clk or negedge i_cptra_rst_b) begin
    if (!i_cptra_rst_b) begin
      r_gated_cnt <= '0;
    end else if (i_gated_cnt_clr) begin
      r_gated_cnt <= '0;
    end else if (w_gated && (r_gated_cnt != '1)) begin
      r_gated_cnt <= r_gated_cnt + 1'b1;
    end
  end

  // psel, force_on and rdc_clk_dis act combinationally for zero-latency restore/override
  assign o_disable_clk         = (w_gated & !w_force_on) | i_rdc_clk_dis;
  assign o_disable_soc_ifc_clk = (w_gated & !w_force_on & !i_psel) | i_rdc_clk_dis;
  assign o_cg_active           = r_cg_active;
  assign o_wake_pulse          = r_wake_pulse;
  assign o_gated_cycle_cnt     = r_gated_cnt;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: main instance (CNT_W=32) plus a
// 4-bit-counter instance held permanently idle for saturation checks.
module tb_clk_gate_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        halt;
  logic        psel;
  logic [63:0] wires;
  logic        fatal;
  logic        dbg;
  logic        rdc;
  logic        clr;
  logic        s_clr;

  logic        dis_clk;
  logic        dis_soc;
  logic        cg;
  logic        wp;
  logic [31:0] cnt;

  logic        s_dis_clk;
  logic        s_dis_soc;
  logic        s_cg;
  logic        s_wp;
  logic [3:0]  s_cnt;

  int n_total;
  int n_bad;
  int cyc;

  clk_gate_ctrl #(.IDLE_CYCLES(16), .MIN_RUN(4), .CNT_W(32)) u_dut (
    .i_clk                      (clk),
    .i_cptra_rst_b              (rst_n),
    .i_clk_gate_en              (en),
    .i_cpu_halt_status          (halt),
    .i_psel                     (psel),
    .i_generic_input_wires      (wires),
    .i_cptra_error_fatal        (fatal),
    .i_cptra_in_debug_scan_mode (dbg),
    .i_rdc_clk_dis              (rdc),
    .i_gated_cnt_clr            (clr),
    .o_disable_clk              (dis_clk),
    .o_disable_soc_ifc_clk      (dis_soc),
    .o_cg_active                (cg),
    .o_wake_pulse               (wp),
    .o_gated_cycle_cnt          (cnt)
  );

  clk_gate_ctrl #(.IDLE_CYCLES(16), .MIN_RUN(4), .CNT_W(4)) u_sat (
    .i_clk                      (clk),
    .i_cptra_rst_b              (rst_n),
    .i_clk_gate_en              (1'b1),
    .i_cpu_halt_status          (1'b1),
    .i_psel                     (1'b0),
    .i_generic_input_wires      (64'd0),
    .i_cptra_error_fatal        (1'b0),
    .i_cptra_in_debug_scan_mode (1'b0),
    .i_rdc_clk_dis              (1'b0),
    .i_gated_cnt_clr            (s_clr),
    .o_disable_clk              (s_dis_clk),
    .o_disable_soc_ifc_clk      (s_dis_soc),
    .o_cg_active                (s_cg),
    .o_wake_pulse               (s_wp),
    .o_gated_cycle_cnt          (s_cnt)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end else begin
      $display("ok   %s cyc=%0d val=%0h", tag, cyc, obs);
    end
  endtask

  // Advance n rising edges; sample point is 1 time unit after the edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Hold at IDLE/RUN status, checking disable_clk stays low up to edge target
  task automatic run_to(input int target, input string tag);
    while (cyc < target) begin
      tick(1);
      if (cyc < target) chk(tag, {31'd0, dis_clk}, 32'd0);
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    en      = 1'b1;
    halt    = 1'b1;
    psel    = 1'b0;
    wires   = 64'd0;
    fatal   = 1'b0;
    dbg     = 1'b0;
    rdc     = 1'b1;
    clr     = 1'b0;
    s_clr   = 1'b0;

    // Reset state: disables follow rdc_clk_dis, status cleared
    #12;
    chk("rst_dis_rdc1", {30'd0, dis_clk, dis_soc}, 32'd3);
    rdc = 1'b0;
    #1;
    chk("rst_dis_rdc0", {30'd0, dis_clk, dis_soc}, 32'd0);
    chk("rst_cg", {31'd0, cg}, 32'd0);
    chk("rst_wp", {31'd0, wp}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    // Gating after 4 holdoff + 1 entry + 16 idle edges
    tick(20);
    chk("pre_gate_dis", {31'd0, dis_clk}, 32'd0);
    chk("pre_gate_cg", {31'd0, cg}, 32'd0);
    tick(1);
    chk("gate_dis", {31'd0, dis_clk}, 32'd1);
    chk("gate_soc", {31'd0, dis_soc}, 32'd1);
    chk("gate_cg", {31'd0, cg}, 32'd1);
    chk("gate_cnt0", cnt, 32'd0);
    tick(1);
    chk("gate_cnt1", cnt, 32'd1);

    // Wire change wakes: WAKE for one cycle, then RUN, re-gate 22 edges after WAKE
    wires[37] = 1'b1;
    tick(1);
    chk("wake_dis", {31'd0, dis_clk}, 32'd0);
    chk("wake_pulse", {31'd0, wp}, 32'd1);
    chk("wake_cg", {31'd0, cg}, 32'd0);
    chk("wake_cnt", cnt, 32'd2);
    tick(1);
    chk("wake_pulse_end", {31'd0, wp}, 32'd0);
    chk("wake_cnt_hold", cnt, 32'd2);
    run_to(45, "regate_wait");
    chk("regate_dis", {31'd0, dis_clk}, 32'd1);
    chk("regate_cg", {31'd0, cg}, 32'd1);

    // psel for 3 cycles: only the soc_ifc disable drops, combinationally
    psel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) tick(1);
      else #1;
      chk("psel_soc", {31'd0, dis_soc}, 32'd0);
      chk("psel_clk", {31'd0, dis_clk}, 32'd1);
      chk("psel_cg", {31'd0, cg}, 32'd1);
    end
    psel = 1'b0;
    #1;
    chk("psel_off_soc", {31'd0, dis_soc}, 32'd1);

    // Fatal error: both disables drop in the same cycle, then WAKE
    fatal = 1'b1;
    #1;
    chk("fatal_dis", {30'd0, dis_clk, dis_soc}, 32'd0);
    chk("fatal_cg_reg", {31'd0, cg}, 32'd1);
    tick(1);
    chk("fatal_wake", {31'd0, wp}, 32'd1);
    fatal = 1'b0;
    tick(1);
    chk("fatal_run_cg", {31'd0, cg}, 32'd0);

    // rdc_clk_dis in RUN: both disables forced high, FSM untouched
    rdc = 1'b1;
    #1;
    chk("rdc_dis", {30'd0, dis_clk, dis_soc}, 32'd3);
    tick(1);
    chk("rdc_dis_hold", {30'd0, dis_clk, dis_soc}, 32'd3);
    chk("rdc_cg", {31'd0, cg}, 32'd0);
    rdc = 1'b0;
    #1;
    chk("rdc_off_dis", {31'd0, dis_clk}, 32'd0);

    // RUN at 49 -> IDLE_WAIT at 54; idle_cnt=5 after edge 64; halt drop aborts
    run_to(64, "iw_wait");
    halt = 1'b0;
    tick(1);
    halt = 1'b1;
    chk("iw_abort_dis", {31'd0, dis_clk}, 32'd0);
    run_to(70, "iw_restart");
    chk("iw_no_early_gate", {31'd0, dis_clk}, 32'd0);
    run_to(86, "iw_full");
    chk("iw_regate_dis", {31'd0, dis_clk}, 32'd1);

    // Clear while gated wins over increment
    clr = 1'b1;
    tick(1);
    chk("clr_cnt", cnt, 32'd0);
    clr = 1'b0;
    tick(1);
    chk("clr_resume", cnt, 32'd1);
    chk("sat_long", {28'd0, s_cnt}, 32'd15);

    // Reset mid-GATED: outputs drop asynchronously
    rst_n = 1'b0;
    #1;
    chk("arst_dis", {30'd0, dis_clk, dis_soc}, 32'd0);
    chk("arst_cg", {31'd0, cg}, 32'd0);
    chk("arst_cnt", cnt, 32'd0);
    chk("arst_sat_cnt", {28'd0, s_cnt}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    cyc   = 0;

    // Saturation on the 4-bit counter: gated at edge 21
    tick(35);
    chk("sat_e", {28'd0, s_cnt}, 32'd14);
    tick(1);
    chk("sat_f", {28'd0, s_cnt}, 32'd15);
    tick(5);
    chk("sat_hold", {28'd0, s_cnt}, 32'd15);
    chk("sat_cg", {31'd0, s_cg}, 32'd1);
    s_clr = 1'b1;
    tick(1);
    chk("sat_clr", {28'd0, s_cnt}, 32'd0);
    s_clr = 1'b0;
    tick(1);
    chk("sat_clr_resume", {28'd0, s_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
Hysteresis and sequencing controller for the Caliptra core/soc_ifc clock gates. It runs on the free-running clock and watches the same idle conditions the ICG disable logic uses. It asserts the gate only after a programmable run of consecutive idle cycles and releases it on any wake event. It enforces a minimum ungated run time after each wake, and it reports gate status, a wake pulse and a saturating gated-cycle counter for firmware telemetry.

Parameters:
IDLE_CYCLES, 16, consecutive idle cycles required in IDLE_WAIT before gating (>=1)
MIN_RUN, 4, minimum cycles spent in RUN after reset or wake before idle qualification may start (>=0)
CNT_W, 32, width of gated-cycle counter

Ports:
clk  input  1  free-running (ungated) clock
cptra_rst_b  input  1  asynchronous active-low reset
clk_gate_en  input  1  firmware enable for clock gating
cpu_halt_status  input  1  core halted
psel  input  1  APB select to soc_ifc
generic_input_wires  input  64  SoC generic wires; any change is a wake event
cptra_error_fatal  input  1  fatal error; forces clocks on
cptra_in_debug_scan_mode  input  1  debug/scan; forces clocks on
rdc_clk_dis  input  1  RDC override; forces both disables high
gated_cnt_clr  input  1  synchronous clear of gated_cycle_cnt
disable_clk  output  1  core clock disable to ICG
disable_soc_ifc_clk  output  1  soc_ifc clock disable to ICG
cg_active  output  1  state==GATED
wake_pulse  output  1  one-cycle pulse on exit from GATED
gated_cycle_cnt  output  CNT_W  cycles spent in GATED, saturating

Behaviour:
- Clock `clk`. Reset `cptra_rst_b` is asynchronous and active-low. All flops reset asynchronously.
- Reset values:
  - state=RUN, holdoff_cnt=MIN_RUN, idle_cnt=0.
  - wires_f=0. Wire change vs 0 after reset is a wake event.
  - gated_cycle_cnt=0, cg_active=0, wake_pulse=0.
  - disable_clk = disable_soc_ifc_clk = rdc_clk_dis.
- Registered wires_f <= generic_input_wires every cycle.
- Definitions:
  - wire_chg = |(generic_input_wires ^ wires_f).
  - force_on = cptra_error_fatal | cptra_in_debug_scan_mode.
  - wake = !clk_gate_en | !cpu_halt_status | wire_chg | force_on.
  - idle = !wake.
- RUN:
  - holdoff_cnt decrements to 0 and stops there.
  - If idle and holdoff_cnt==0: go to IDLE_WAIT, load idle_cnt=IDLE_CYCLES-1.
- IDLE_WAIT:
  - wake has priority: go to RUN, reload holdoff_cnt=MIN_RUN.
  - Else if idle_cnt==0: go to GATED.
  - Else decrement idle_cnt.
- GATED:
  - If wake: go to WAKE.
  - psel does not change state.
- WAKE:
  - Single cycle. wake_pulse=1. Go to RUN, reload holdoff_cnt=MIN_RUN.
- Outputs:
  - disable_clk = ((state==GATED) & !force_on) | rdc_clk_dis.
  - disable_soc_ifc_clk = ((state==GATED) & !force_on & !psel) | rdc_clk_dis.
  - psel and force_on reach the outputs combinationally, so APB access and fatal/debug get zero-latency clock restore.
- Latency:
  - Idle continuous from a RUN cycle with holdoff_cnt==0 gives disable_clk=1 exactly IDLE_CYCLES+1 cycles later.
  - A wake seen in GATED deasserts disable_clk on the next cycle.
  - Exception: force_on deasserts disable_clk in the same cycle.
- cg_active = (state==GATED), registered state decode. It ignores rdc_clk_dis.
- gated_cycle_cnt:
  - +1 each cycle in GATED; saturates at all-ones.
  - gated_cnt_clr has priority over the increment.
- Simultaneous events:
  - wake and idle_cnt==0 in IDLE_WAIT: RUN.
  - wake on the same cycle as entry to GATED is evaluated next cycle: GATED lasts at least 1 cycle.
- rdc_clk_dis does not affect the FSM.
- Reset mid-GATED: disables drop to rdc_clk_dis asynchronously, FSM returns to RUN.

Test Plan:
- IDLE_CYCLES=16, MIN_RUN=4. Release reset with clk_gate_en=1, halt=1, wires stable: disable_clk rises on cycle 4+1+16 after reset; cg_active=1 same cycle; counter increments from next cycle.
- In GATED, toggle generic_input_wires[37] once: next cycle state=WAKE, disable_clk=0, wake_pulse=1 for 1 cycle. Re-gating takes MIN_RUN+IDLE_CYCLES+1 cycles.
- In IDLE_WAIT with idle_cnt=5, drop cpu_halt_status for 1 cycle: return to RUN with holdoff reload. disable_clk stays 0; the full count restarts.
- In GATED, assert psel for 3 cycles: disable_soc_ifc_clk=0 in those same 3 cycles, disable_clk=1 throughout, cg_active=1.
- In GATED, assert cptra_error_fatal: both disables 0 in the same cycle. Assert rdc_clk_dis in RUN: both disables 1 and state unchanged.
- Preload gated_cycle_cnt to all-ones (CNT_W=4, 20 gated cycles): holds at 4'hF. Assert gated_cnt_clr while gated: next value 0.
